// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one 32-bit shifter between two requesters (port 0: ALU execute stage,
// port 1: multdiv/auxiliary unit). Grants are round-robin with valid/ready
// handshakes. Results go into a single registered output slot, tagged with the
// id of the requester that produced them.
//
// Optional feature macro: SHIFT_ARB_EXT_OPS_EN
//   defined   : op 10 = logical right shift, op 11 = rotate right, rsp_err = 0
//   undefined : op 10/11 are accepted but answered with rsp_data = 0 and
//               rsp_err = 1; no extra shift hardware is built
//
// Ports
//   clock                  rising-edge clock
//   reset_n                asynchronous active-low reset
//   req0_valid/req0_ready  port 0 handshake (ready = granted this cycle)
//   req0_data              port 0 operand
//   req0_shamt             port 0 shift amount
//   req0_op                port 0 op: 00 sll, 01 sra, 10 srl*, 11 ror*
//   req1_*                 same as port 0, for port 1
//   rsp_valid              result slot full
//   rsp_ready              consumer accepts the result
//   rsp_data               shifted result
//   rsp_id                 requester that produced rsp_data
//   rsp_err                unsupported op flag
//   busy                   slot full, or any request valid
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int PRIO_INIT   = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  input  logic [1:0]             req0_op,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  input  logic [1:0]             req1_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e state;
  logic  prio;          // port that wins when both requesters are valid

  logic                   can_accept;
  logic                   gnt0;
  logic                   gnt1;
  logic                   vld_p0;
  logic [DATA_WIDTH-1:0]  data_p0;
  logic [SHAMT_WIDTH-1:0] shamt_p0;
  logic [1:0]             op_p0;
  logic [DATA_WIDTH-1:0]  res_p0;
  logic                   err_p0;

  // Shifter datapath. The sra path goes through an explicitly signed copy so
  // that >>> replicates bit 31.
  function automatic logic [DATA_WIDTH-1:0] shift_result(
    input logic [DATA_WIDTH-1:0]  data,
    input logic [SHAMT_WIDTH-1:0] shamt,
    input logic [1:0]             op
  );
    logic signed [DATA_WIDTH-1:0] sdata;
`ifdef SHIFT_ARB_EXT_OPS_EN
    logic [2*DATA_WIDTH-1:0]      dbl;
`endif
    sdata = data;
    shift_result = '0;
    case (op)
      2'b00: shift_result = data << shamt;
      2'b01: shift_result = sdata >>> shamt;
`ifdef SHIFT_ARB_EXT_OPS_EN
      2'b10: shift_result = data >> shamt;
      default: begin
        // Rotate: shifting a doubled copy right brings the low bits around
        // into the top of the lower half.
        dbl          = {data, data} >> shamt;
        shift_result = dbl[DATA_WIDTH-1:0];
      end
`else
      default: shift_result = '0;
`endif
    endcase
  endfunction

  function automatic logic op_error(input logic [1:0] op);
`ifdef SHIFT_ARB_EXT_OPS_EN
    op_error = 1'b0;
`else
    op_error = op[1];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: combinational grant and operand select
  // ---------------------------------------------------------------------------
  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    gnt0       = can_accept && req0_valid && (!req1_valid || (prio == 1'b0));
    gnt1       = can_accept && req1_valid && (!req0_valid || (prio == 1'b1));
    vld_p0     = gnt0 || gnt1;

    // Readys are forced low while reset is asserted, even though the grant
    // logic itself only sees registered state.
    req0_ready = gnt0 && reset_n;
    req1_ready = gnt1 && reset_n;

    data_p0  = gnt1 ? req1_data  : req0_data;
    shamt_p0 = gnt1 ? req1_shamt : req0_shamt;
    op_p0    = gnt1 ? req1_op    : req0_op;

    res_p0 = shift_result(data_p0, shamt_p0, op_p0);
    err_p0 = op_error(op_p0);

    busy = rsp_valid || req0_valid || req1_valid;
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered result slot and priority pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      prio      <= 1'(PRIO_INIT);
    end else begin
      if (vld_p0) begin
        // A grant overwrites the slot whether it was empty or being drained
        // this cycle, which gives one result per cycle with no bubble.
        state     <= FULL;
        rsp_valid <= 1'b1;
        rsp_data  <= res_p0;
        rsp_id    <= gnt1;
        rsp_err   <= err_p0;
        prio      <= gnt0;   // the port not granted gets priority next
      end else begin
        case (state)
          FULL: begin
            if (rsp_ready) begin
              state     <= EMPTY;
              rsp_valid <= 1'b0;
            end
          end
          default: begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed bench for shift_arbiter (PRIO_INIT = 0). Inputs change 1 time unit
// after each rising edge; ready is sampled mid-cycle and results are sampled
// 1 time unit after the edge that registers them.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;
  logic        busy;

  int checks;
  int failures;

  shift_arbiter #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5),
    .PRIO_INIT  (0)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data (req0_data),
    .req0_shamt(req0_shamt),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data (req1_data),
    .req1_shamt(req1_shamt),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req0_shamt = '0;
    req0_op    = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    req1_shamt = '0;
    req1_op    = '0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h want=00000000", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_valid got=%b want=1", busy); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid got=%b want=0", rsp_valid); end
  endtask

  task automatic test_port0_sra();
    req0_valid = 1'b1;
    req0_data  = 32'h8000_0001;
    req0_shamt = 5'd4;
    req0_op    = 2'b01;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL p0_ready got=%b want=10", {req0_ready, req1_ready}); end
    next_cycle();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL p0_rsp_valid got=%b want=1", rsp_valid); end
    checks++; if (rsp_data !== 32'hF800_0000) begin failures++; $display("FAIL p0_rsp_data got=%h want=f8000000", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL p0_rsp_id got=%b want=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL p0_rsp_err got=%b want=0", rsp_err); end
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL p0_drain got=%b want=0", rsp_valid); end
  endtask

  task automatic test_port1_shifts();
    req1_valid = 1'b1;
    req1_data  = 32'h0000_0003;
    req1_shamt = 5'd31;
    req1_op    = 2'b00;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL p1_ready got=%b want=01", {req0_ready, req1_ready}); end
    next_cycle();
    checks++; if (rsp_data !== 32'h8000_0000) begin failures++; $display("FAIL p1_sll31 got=%h want=80000000", rsp_data); end
    checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL p1_rsp_id got=%b want=1", rsp_id); end
    req1_data  = 32'h1234_5678;
    req1_shamt = 5'd0;
    req1_op    = 2'b01;
    next_cycle();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h1234_5678}) begin failures++; $display("FAIL p1_sra0 got=%b/%h want=1/12345678", rsp_valid, rsp_data); end
    req1_data  = 32'h8000_0000;
    req1_shamt = 5'd31;
    req1_op    = 2'b01;
    next_cycle();
    checks++; if (rsp_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL p1_sra31 got=%h want=ffffffff", rsp_data); end
    req1_data  = 32'h0000_FFFF;
    req1_shamt = 5'd8;
    req1_op    = 2'b00;
    next_cycle();
    checks++; if (rsp_data !== 32'h00FF_FF00) begin failures++; $display("FAIL p1_sll8 got=%h want=00ffff00", rsp_data); end
    req1_valid = 1'b0;
    next_cycle();
  endtask

  // Priority is back at port 0 here (last grant went to port 1).
  task automatic test_fairness();
    req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 32'h1; req1_shamt = 5'd2; req1_op = 2'b00;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL fair_ready[%0d] got=%b want=%b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      next_cycle();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'(i % 2), ((i % 2 == 0) ? 32'h2 : 32'h4)}) begin
        failures++;
        $display("FAIL fair_rsp[%0d] got=%b/%b/%h want=1/%0d/%h", i, rsp_valid, rsp_id, rsp_data, i % 2, (i % 2 == 0) ? 32'h2 : 32'h4);
      end
    end
  endtask

  // Continues from fairness: slot holds id 1 / data 4, both ports still valid.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=00", i, {req0_ready, req1_ready}); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy[%0d] got=%b want=1", i, busy); end
      next_cycle();
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'h4}) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%b/%h want=1/1/00000004", i, rsp_valid, rsp_id, rsp_data); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL bp_release_ready got=%b want=10", {req0_ready, req1_ready}); end
    next_cycle();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h2}) begin failures++; $display("FAIL bp_release_rsp got=%b/%b/%h want=1/0/00000002", rsp_valid, rsp_id, rsp_data); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", rsp_valid); end
  endtask

  task automatic test_ext_ops();
    logic [31:0] want_srl;
    logic [31:0] want_ror;
    logic        want_err;
`ifdef SHIFT_ARB_EXT_OPS_EN
    want_srl = 32'h0F00_0000;
    want_ror = 32'hF000_0000;
    want_err = 1'b0;
`else
    want_srl = 32'h0;
    want_ror = 32'h0;
    want_err = 1'b1;
`endif
    req0_valid = 1'b1;
    req0_data  = 32'hF000_0000;
    req0_shamt = 5'd4;
    req0_op    = 2'b10;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL ext_op10_ready got=%b want=1", req0_ready); end
    next_cycle();
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, want_srl, want_err}) begin failures++; $display("FAIL ext_op10 got=%b/%h/%b want=1/%h/%b", rsp_valid, rsp_data, rsp_err, want_srl, want_err); end
    req0_data = 32'h0000_000F;
    req0_op   = 2'b11;
    next_cycle();
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, want_ror, want_err}) begin failures++; $display("FAIL ext_op11 got=%b/%h/%b want=1/%h/%b", rsp_valid, rsp_data, rsp_err, want_ror, want_err); end
    req0_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_async_reset();
    // Grant port 0 so the pointer moves to 1, then hold the result.
    req0_valid = 1'b1;
    req0_data  = 32'h0000_00AA;
    req0_shamt = 5'd4;
    req0_op    = 2'b00;
    next_cycle();
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000_0AA0}) begin failures++; $display("FAIL ar_fill got=%b/%h want=1/00000aa0", rsp_valid, rsp_data); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b0, 32'h0}) begin failures++; $display("FAIL ar_async_clear got=%b/%h want=0/00000000", rsp_valid, rsp_data); end
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    next_cycle();
    // Both valid: the restored pointer must favour port 0 again.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 32'h1;
    req1_shamt = 5'd0;
    req1_op    = 2'b00;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL ar_prio_restore got=%b want=10", {req0_ready, req1_ready}); end
    next_cycle();
    checks++; if ({rsp_valid, rsp_id} !== {1'b1, 1'b0}) begin failures++; $display("FAIL ar_first_grant got=%b/%b want=1/0", rsp_valid, rsp_id); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_port0_sra();
    test_port1_shifts();
    test_fairness();
    test_backpressure();
    test_ext_ops();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
